prv_trap_sequencer: RTL

PRV_TRAP_SEQUENCER -- requirements
Module: prv_trap_sequencer

---
 rtl/prv_trap_sequencer_pkg.sv | 42 ++++
 rtl/prv_trap_sequencer_priority.sv | 25 ++
 rtl/prv_trap_sequencer.sv | 108 ++++++++++
 3 files changed

// File: rtl/prv_trap_sequencer_pkg.sv
// Machine-mode trap types shared by the trap sequencer and its exception priority encoder.
package prv_trap_sequencer_pkg;

    typedef enum logic [3:0] {
        EX_MAL_INSN    = 4'd0,
        EX_FAULT_INSN  = 4'd1,
        EX_ILLEGAL     = 4'd2,
        EX_BREAKPOINT  = 4'd3,
        EX_MAL_L       = 4'd4,
        EX_FAULT_L     = 4'd5,
        EX_MAL_S       = 4'd6,
        EX_FAULT_S     = 4'd7,
        EX_ENV         = 4'd11
    } ex_code_t;

    typedef enum logic [3:0] {
        INT_S_SOFT  = 4'd1,
        INT_M_SOFT  = 4'd3,
        INT_S_TIMER = 4'd5,
        INT_M_TIMER = 4'd7,
        INT_S_EXT   = 4'd9,
        INT_M_EXT   = 4'd11
    } int_code_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_INSERT   = 2'd2,
        ST_RET      = 2'd3
    } trap_state_t;

    localparam int EXC_MAL_INSN   = 0;
    localparam int EXC_FAULT_INSN = 1;
    localparam int EXC_ILLEGAL    = 2;
    localparam int EXC_BREAKPOINT = 3;
    localparam int EXC_MAL_L      = 4;
    localparam int EXC_FAULT_L    = 5;
    localparam int EXC_MAL_S      = 6;
    localparam int EXC_FAULT_S    = 7;
    localparam int EXC_ENV        = 8;

endpackage

// File: rtl/prv_trap_sequencer_priority.sv
// Combinational exception priority encoder: picks the single cause to report when
// several exception flags are raised together.
import prv_trap_sequencer_pkg::*;

module prv_exception_priority (
    input  logic [8:0] exc_vec,
    output logic       valid,
    output ex_code_t   code
);

    always_comb begin
        valid = |exc_vec;
        code  = EX_MAL_INSN;
        if (exc_vec[EXC_BREAKPOINT])      code = EX_BREAKPOINT;
        else if (exc_vec[EXC_FAULT_INSN]) code = EX_FAULT_INSN;
        else if (exc_vec[EXC_MAL_INSN])   code = EX_MAL_INSN;
        else if (exc_vec[EXC_ILLEGAL])    code = EX_ILLEGAL;
        else if (exc_vec[EXC_ENV])        code = EX_ENV;
        else if (exc_vec[EXC_MAL_S])      code = EX_MAL_S;
        else if (exc_vec[EXC_MAL_L])      code = EX_MAL_L;
        else if (exc_vec[EXC_FAULT_S])    code = EX_FAULT_S;
        else if (exc_vec[EXC_FAULT_L])    code = EX_FAULT_L;
    end

endmodule

// File: rtl/prv_trap_sequencer.sv
// Machine-mode trap sequencer: latches mepc/mcause/mtval and issues a one-cycle PC redirect.
// Define VECTORED_INTR_EN to enable vectored interrupt dispatch (mtvec[1:0]==2'b01).
import prv_trap_sequencer_pkg::*;

// state    | meaning
// IDLE     | no trap in flight; exceptions, interrupts and ret accepted
// WAIT_MEM | trap latched, waiting for the memory stage to drain
// INSERT   | redirect to trap vector for one cycle
// RET      | redirect to mepc for one cycle
module prv_trap_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [8:0]      exc_vec,
    input  logic            wb_enable,
    input  logic            ex_mem_stall,
    input  logic            intr_pending,
    input  logic [3:0]      intr_cause,
    input  logic            ret,
    input  logic [XLEN-1:0] epc,
    input  logic [XLEN-1:0] badaddr,
    input  logic [XLEN-1:0] mtvec,
    output logic            intr,
    output logic            insert_pc,
    output logic [XLEN-1:0] priv_pc,
    output logic [XLEN-1:0] mepc,
    output logic [XLEN-1:0] mcause,
    output logic [XLEN-1:0] mtval,
    output logic            trap_busy
);

    trap_state_t     state, state_next;
    logic            exc_valid;
    ex_code_t        exc_code;
    logic            take_exc, take_intr;
    logic [XLEN-1:0] trap_base, trap_target;

    prv_exception_priority u_prio (
        .exc_vec (exc_vec),
        .valid   (exc_valid),
        .code    (exc_code)
    );

    assign intr      = intr_pending && !exc_valid && (state == ST_IDLE);
    assign take_exc  = (state == ST_IDLE) && exc_valid && wb_enable;
    assign take_intr = intr && !ex_mem_stall;
    assign trap_busy = (state != ST_IDLE);
    assign trap_base = mtvec & ~XLEN'(3);

`ifdef VECTORED_INTR_EN
    // Mode bits are sampled at redirect time; the latched mcause says whether it was an interrupt.
    assign trap_target = (mtvec[1:0] == 2'b01 && mcause[XLEN-1])
                       ? trap_base + XLEN'({mcause[3:0], 2'b00})
                       : trap_base;
`else
    assign trap_target = trap_base;
`endif

    always_ff @(posedge CLK) begin
        if (!nRST) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        insert_pc  = 1'b0;
        priv_pc    = '0;
        case (state)
            ST_IDLE: begin
                if (take_exc)       state_next = ex_mem_stall ? ST_WAIT_MEM : ST_INSERT;
                else if (take_intr) state_next = ST_INSERT;
                else if (ret)       state_next = ST_RET;
            end
            ST_WAIT_MEM: begin
                if (!ex_mem_stall) state_next = ST_INSERT;
            end
            ST_INSERT: begin
                insert_pc  = 1'b1;
                priv_pc    = trap_target;
                state_next = ST_IDLE;
            end
            ST_RET: begin
                insert_pc  = 1'b1;
                priv_pc    = mepc;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            mepc   <= '0;
            mcause <= '0;
            mtval  <= '0;
        end else if (take_exc) begin
            mepc   <= epc;
            mcause <= {{(XLEN-4){1'b0}}, exc_code};
            mtval  <= badaddr;
        end else if (take_intr) begin
            mepc   <= epc;
            mcause <= {1'b1, {(XLEN-5){1'b0}}, intr_cause};
            mtval  <= '0;
        end
    end

endmodule
